segre_dmmu_refill: RTL



---
 rtl/segre_dmmu_refill_if.sv | 37 +++
 rtl/segre_dmmu_refill.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/segre_dmmu_refill_if.sv
// Data-cache miss/writeback/LRU bus plus the line-wide main-memory port.
// slave = the DMMU responder; master = pipeline and memory side driving it.
interface segre_dmmu_refill_if #(
  parameter int ADDR_SIZE         = 32,
  parameter int DCACHE_LANE_SIZE  = 128,
  parameter int DCACHE_INDEX_SIZE = 2
);
  logic                         dc_miss_i;
  logic [ADDR_SIZE-1:0]         dc_addr_i;
  logic                         dc_cache_access_i;
  logic                         dc_writeback_i;
  logic [DCACHE_LANE_SIZE-1:0]  dc_data_i;
  logic                         dc_data_rdy_o;
  logic [ADDR_SIZE-1:0]         dc_addr_o;
  logic [DCACHE_LANE_SIZE-1:0]  dc_data_o;
  logic [DCACHE_INDEX_SIZE-1:0] dc_lru_index_o;
  logic                         mem_req_o;
  logic                         mem_we_o;
  logic [ADDR_SIZE-1:0]         mem_addr_o;
  logic [DCACHE_LANE_SIZE-1:0]  mem_wdata_o;
  logic                         mem_ack_i;
  logic [DCACHE_LANE_SIZE-1:0]  mem_rdata_i;

  modport slave (
    input  dc_miss_i, dc_addr_i, dc_cache_access_i, dc_writeback_i, dc_data_i,
           mem_ack_i, mem_rdata_i,
    output dc_data_rdy_o, dc_addr_o, dc_data_o, dc_lru_index_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output dc_miss_i, dc_addr_i, dc_cache_access_i, dc_writeback_i, dc_data_i,
           mem_ack_i, mem_rdata_i,
    input  dc_data_rdy_o, dc_addr_o, dc_data_o, dc_lru_index_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/segre_dmmu_refill.sv
// Data-side MMU responder: drains dirty-line writebacks, refills missing lines
// and owns the data-cache tag mirror and true-LRU replacement state.
module segre_dmmu_refill #(
  parameter int ADDR_SIZE         = 32,
  parameter int DCACHE_LANE_SIZE  = 128,
  parameter int DCACHE_INDEX_SIZE = 2,
  parameter int LINE_OFFSET       = 4
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  segre_dmmu_refill_if.slave  bus
);
  localparam int NUM_LANES = 2 ** DCACHE_INDEX_SIZE;
  localparam int IDX_W     = DCACHE_INDEX_SIZE;
  localparam int LINE_W    = ADDR_SIZE - LINE_OFFSET;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_RD, S_RESP} state_e;
  typedef logic [NUM_LANES-1:0][IDX_W-1:0] age_vec_t;

  state_e                      r_state;
  state_e                      w_state_next;
  logic                        r_wb_full;
  logic [LINE_W-1:0]           r_wb_line;
  logic [DCACHE_LANE_SIZE-1:0] r_wb_data;
  logic [LINE_W-1:0]           r_miss_line;
  logic [DCACHE_LANE_SIZE-1:0] r_rdata;
  logic [LINE_W-1:0]           r_tag [NUM_LANES];
  logic [NUM_LANES-1:0]        r_valid;
  age_vec_t                    r_age;

  logic [LINE_W-1:0]           w_addr_line;
  logic [LINE_OFFSET-1:0]      w_unused_addr_bits;
  logic [IDX_W-1:0]            w_victim;
  logic                        w_victim_found;
  logic                        w_hit;
  logic [IDX_W-1:0]            w_hit_lane;
  age_vec_t                    w_age_hit;
  age_vec_t                    w_age_next;

  assign w_addr_line        = bus.dc_addr_i[ADDR_SIZE-1:LINE_OFFSET];
  assign w_unused_addr_bits = bus.dc_addr_i[LINE_OFFSET-1:0];

  // Touching lane k makes it youngest and ages everything younger than it.
  function automatic age_vec_t lru_touch(input age_vec_t ages, input logic [IDX_W-1:0] k);
    age_vec_t res;
    res = ages;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (ages[i] < ages[k]) res[i] = ages[i] + IDX_W'(1);
    end
    res[k] = '0;
    return res;
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_victim       = '0;
    w_victim_found = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!r_valid[i] && !w_victim_found) begin
        w_victim       = IDX_W'(i);
        w_victim_found = 1'b1;
      end
    end
    if (!w_victim_found) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (r_age[i] == IDX_W'(NUM_LANES - 1)) w_victim = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_hit      = 1'b0;
    w_hit_lane = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (bus.dc_cache_access_i && r_valid[i] && (r_tag[i] == w_addr_line)) begin
        w_hit      = 1'b1;
        w_hit_lane = IDX_W'(i);
      end
    end
  end

  // A hit and a refill in the same cycle: the refill touch is applied last.
  always_comb begin
    w_age_hit  = w_hit ? lru_touch(r_age, w_hit_lane) : r_age;
    w_age_next = (r_state == S_RESP) ? lru_touch(w_age_hit, w_victim) : w_age_hit;
  end

  always_comb begin
    w_state_next       = r_state;
    bus.mem_req_o      = 1'b0;
    bus.mem_we_o       = 1'b0;
    bus.mem_addr_o     = '0;
    bus.mem_wdata_o    = '0;
    bus.dc_data_rdy_o  = 1'b0;
    bus.dc_addr_o      = '0;
    bus.dc_data_o      = '0;
    bus.dc_lru_index_o = '0;
    case (r_state)
      S_IDLE: begin
        if (r_wb_full)          w_state_next = S_WB;
        else if (bus.dc_miss_i) w_state_next = S_RD;
      end
      S_WB: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = {r_wb_line, {LINE_OFFSET{1'b0}}};
        bus.mem_wdata_o = r_wb_data;
        if (bus.mem_ack_i) w_state_next = bus.dc_miss_i ? S_RD : S_IDLE;
      end
      S_RD: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = {r_miss_line, {LINE_OFFSET{1'b0}}};
        if (bus.mem_ack_i) w_state_next = S_RESP;
      end
      S_RESP: begin
        bus.dc_data_rdy_o  = 1'b1;
        bus.dc_addr_o      = {r_miss_line, {LINE_OFFSET{1'b0}}};
        bus.dc_data_o      = r_rdata;
        bus.dc_lru_index_o = w_victim;
        w_state_next       = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      r_state     <= S_IDLE;
      r_wb_full   <= 1'b0;
      r_wb_line   <= '0;
      r_wb_data   <= '0;
      r_miss_line <= '0;
      r_rdata     <= '0;
      r_valid     <= '0;
      for (int i = 0; i < NUM_LANES; i++) r_age[i] <= IDX_W'(i);
    end else begin
      r_state <= w_state_next;
      r_age   <= w_age_next;
      if (bus.dc_writeback_i) begin
        r_wb_full <= 1'b1;
        r_wb_line <= w_addr_line;
        r_wb_data <= bus.dc_data_i;
      end else if (r_state == S_WB && bus.mem_ack_i) begin
        r_wb_full <= 1'b0;
      end
      if (w_state_next == S_RD && r_state != S_RD) r_miss_line <= w_addr_line;
      if (r_state == S_RD && bus.mem_ack_i) r_rdata <= bus.mem_rdata_i;
      if (r_state == S_RESP) r_valid[w_victim] <= 1'b1;
    end
  end

  // NOTE: the tag mirror has no reset; valid bits gate every use of a tag.
  always_ff @(posedge clk_i) begin
    if (rsn_i && r_state == S_RESP) r_tag[w_victim] <= r_miss_line;
  end

  a_wb_overflow: assert property (@(posedge clk_i) disable iff (!rsn_i)
    bus.dc_writeback_i |-> !r_wb_full)
    else $fatal(1, "writeback while the writeback buffer is full");

  a_wb_with_miss: assert property (@(posedge clk_i) disable iff (!rsn_i)
    !(bus.dc_writeback_i && $rose(bus.dc_miss_i)))
    else $fatal(1, "writeback and new miss in the same cycle");
endmodule
